// File: rtl/var_shift_engine.sv
// -----------------------------------------------------------------------------
// var_shift_engine
//   Multi-cycle variable shifter. An operand is accepted from IDLE on start,
//   then shifted by up to STEP positions per enabled clock until the requested
//   amount is consumed. Supports logical, arithmetic and rotate modes in
//   either direction. A one-cycle done pulse marks completion.
//
//   Optional build macro: VAR_SHIFT_STICKY_EN adds the 'sticky' output, the OR
//   of every non-rotate bit shifted out during the operation.
//
// Parameters
//   WIDTH : data width (>= 2)
//   SHW   : shift-amount width
//   STEP  : max bit positions shifted per cycle (1..WIDTH)
//
// Ports
//   clk    in   rising-edge clock
//   clr    in   asynchronous active-high reset
//   start  in   request, sampled only in IDLE
//   en     in   shift enable; low freezes an operation in progress
//   dir    in   0 = left, 1 = right (captured at accept)
//   mode   in   00 logical, 01 arithmetic, 10 rotate, 11 logical
//   in     in   operand (captured at accept)
//   shift  in   shift amount (captured at accept)
//   q      out  working/result register
//   busy   out  high while shifting
//   done   out  one-cycle completion pulse
//   sticky out  (VAR_SHIFT_STICKY_EN only) OR of shifted-out bits
// -----------------------------------------------------------------------------
module var_shift_engine #(
    parameter int WIDTH = 32,
    parameter int SHW   = 6,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             en,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] in,
    input  logic [SHW-1:0]   shift,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
`ifdef VAR_SHIFT_STICKY_EN
    ,
    output logic             sticky
`endif
);

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    localparam logic [WIDTH-1:0] ONES = '1;

    state_t           r_state, w_next_state;
    logic [WIDTH-1:0] r_q;
    logic [SHW-1:0]   r_rem;
    logic             r_dir;
    logic [1:0]       r_mode;
    logic             r_done;

    logic [31:0]      w_rem32;
    logic [31:0]      w_k;
    logic             w_last;
    logic             w_accept;
    logic             w_step;
    logic [WIDTH-1:0] w_shifted;

    // Positions moved this cycle: k = min(STEP, rem). Compared in 32 bits so
    // STEP may exceed what SHW can represent.
    assign w_rem32  = 32'(r_rem);
    assign w_k      = (w_rem32 < 32'(STEP)) ? w_rem32 : 32'(STEP);
    assign w_last   = (w_rem32 == w_k);
    assign w_accept = (r_state == S_IDLE) && start;
    assign w_step   = (r_state == S_SHIFT) && en;

    // One step of k positions. k never exceeds WIDTH, so the rotate
    // complement shift (WIDTH-k) stays in range; k == WIDTH returns q.
    always_comb begin
        w_shifted = r_q;
        if (!r_dir) begin
            if (r_mode == 2'b10)
                w_shifted = (r_q << w_k) | (r_q >> (32'(WIDTH) - w_k));
            else
                w_shifted = r_q << w_k;
        end else begin
            if (r_mode == 2'b10)
                w_shifted = (r_q >> w_k) | (r_q << (32'(WIDTH) - w_k));
            else if (r_mode == 2'b01)
                w_shifted = WIDTH'($signed(r_q) >>> w_k);
            else
                w_shifted = r_q >> w_k;
        end
    end

`ifdef VAR_SHIFT_STICKY_EN
    logic             r_sticky;
    logic [WIDTH-1:0] w_out_mask;

    // Bits leaving the register this step: top k going left, bottom k going right.
    assign w_out_mask = r_dir ? ~(ONES << w_k) : ~(ONES >> w_k);

    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            r_sticky <= 1'b0;
        else if (w_accept)
            r_sticky <= 1'b0;
        else if (w_step && (r_mode != 2'b10))
            r_sticky <= r_sticky | (|(r_q & w_out_mask));
    end

    assign sticky = r_sticky;
`endif

    // State register
    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            r_state <= S_IDLE;
        else
            r_state <= w_next_state;
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start && (shift != '0)) w_next_state = S_SHIFT;
            S_SHIFT: if (en && w_last)           w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Datapath and completion pulse
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_q    <= '0;
            r_rem  <= '0;
            r_dir  <= 1'b0;
            r_mode <= 2'b00;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_q    <= in;
                r_rem  <= shift;
                r_dir  <= dir;
                r_mode <= mode;
                r_done <= (shift == '0);
            end else if (w_step) begin
                r_q    <= w_shifted;
                r_rem  <= r_rem - SHW'(w_k);
                r_done <= w_last;
            end
        end
    end

    // Outputs
    always_comb begin
        q    = r_q;
        busy = (r_state == S_SHIFT);
        done = r_done;
    end

endmodule

// File: doc/var_shift_engine.md
Name: var_shift_engine

Overview:
- Parametrised, multi-cycle variable shifter. Successor to the fixed 32-bit variable shifter.
- Generalised in width, shift-amount width and bits-per-cycle.
- Adds logical, arithmetic and rotate modes, a start/busy/done handshake and a pause enable.
- Sits between a register-file style operand source and a consumer that waits on done.

Parameters:
- WIDTH, 32: data width in bits, ≥2.
- SHW, 6: shift-amount port width; amounts up to 2^SHW-1 are legal, including ≥ WIDTH.
- STEP, 1: maximum bit positions shifted per cycle, 1..WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- clr  in  1  asynchronous active-high reset.
- start  in  1  request; sampled only in IDLE.
- en  in  1  shift enable; low freezes an operation in progress.
- dir  in  1  0 = left, 1 = right; captured at accept.
- mode  in  2  00 logical, 01 arithmetic, 10 rotate, 11 treated as logical; captured at accept.
- in  in  WIDTH  operand; captured at accept.
- shift  in  SHW  shift amount; captured at accept.
- q  out  WIDTH  working/result register.
- busy  out  1  high while in SHIFT.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Clocking/reset: one clock, clk. Reset clr is asynchronous and active-high. clr forces state = IDLE, q = 0, busy = 0, done = 0, and clears the internal remaining counter. clr mid-operation aborts immediately; no done pulse follows.
- States: IDLE and SHIFT.
- IDLE accept: on a clk edge with start = 1, load q <= in, latch dir, mode and rem <= shift. en is not required for accept.
  - If shift == 0: stay in IDLE and set done <= 1 for one cycle.
  - Otherwise: go to SHIFT and set busy <= 1.
- SHIFT, edge with en = 1:
  - k = min(STEP, rem). Shift q by k positions in the latched dir and mode. rem <= rem − k.
  - If rem − k == 0: go to IDLE with busy <= 0 and done <= 1 for exactly one cycle.
- SHIFT, edge with en = 0: q, rem and state hold; busy stays 1.
- Latency: N = ceil(shift/STEP) enabled edges after the accept edge. done is high for the cycle after the N-th enabled edge. For shift = 0, done is high for the cycle after the accept edge.
- Back-to-back: done and a new accept may coincide, because the FSM is already in IDLE when done is high. start while busy is ignored.
- Mode rules per step:
  - Logical: vacated bits fill with 0.
  - Arithmetic right: vacated bits fill with the current q[WIDTH-1]. Arithmetic left behaves as logical left.
  - Rotate: bits shifted out re-enter at the opposite end.
- Large amounts (shift ≥ WIDTH), no special case: logical yields 0, arithmetic right yields all sign bits, rotate yields rotation by shift mod WIDTH. All cost the full N cycles.
- q holds its value in IDLE until the next accept or clr.

Optional Feature:
- Macro VAR_SHIFT_STICKY_EN adds output port sticky (1 bit).
- sticky resets to 0 on clr and clears at accept.
- Each enabled SHIFT step sets sticky to sticky OR'd with the OR of all non-rotate bits shifted out that step. Rotate mode never sets sticky.
- sticky is valid when done is high and holds in IDLE.
- Without the macro, the port and its logic are absent. All other behaviour is identical.

Test Plan:
- WIDTH = 32, STEP = 1: in = 0x000001A6, shift = 4, dir = 0, mode = 00 -> busy for 4 cycles, then done pulse with q = 0x00001A60.
- in = 0x80000000, shift = 4, dir = 1, mode = 01 -> q = 0xF8000000 at done. Repeat with mode = 00 -> q = 0x08000000.
- in = 0x000001A6, shift = 8, dir = 1, mode = 10 -> q = 0xA6000001. Repeat with STEP = 3 -> done after 3 cycles with the same q.
- shift = 0 -> done is high the cycle after accept, q = in, busy never asserts. shift = 40, logical left, STEP = 1 -> q = 0 after 40 cycles.
- en low for 5 cycles mid-operation -> q and busy hold, and the latency extends by exactly 5. clr asserted mid-operation -> q = 0 and busy = 0 immediately, no done pulse. start while busy -> ignored.
- With VAR_SHIFT_STICKY_EN, 0x000001A6 right logical: by 4 -> sticky = 1; by 1 -> sticky = 0.
